// File: rtl/pixel_write_queue_if.sv
// Pixel bus from the drawers plus the framebuffer write handshake.
// master drives strobes and fb_ready; slave is the write queue.
interface pixel_write_queue_if #(
  parameter int CH_BITS = 3
);
  logic                   draw_enable_in;
  logic [7:0]             x_in;
  logic [7:0]             y_in;
  logic [23:0]            rgb_in;
  logic                   fb_ready;
  logic                   fb_we;
  logic [14:0]            fb_addr;
  logic [3*CH_BITS-1:0]   fb_colour;

  modport master (
    output draw_enable_in, x_in, y_in, rgb_in, fb_ready,
    input  fb_we, fb_addr, fb_colour
  );

  modport slave (
    input  draw_enable_in, x_in, y_in, rgb_in, fb_ready,
    output fb_we, fb_addr, fb_colour
  );
endinterface

// File: rtl/pixel_write_queue.sv
// Buffers pixel strobes, converts (x,y) to a linear address and RGB888 to
// reduced depth, then drains to the framebuffer over ready/valid.
module pixel_write_queue #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CH_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  pixel_write_queue_if.slave   bus,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [7:0]           oob_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 3 * CH_BITS;

  typedef struct packed {
    logic [14:0]   addr;
    logic [CW-1:0] colour;
  } entry_t;

  typedef enum logic {OUT_IDLE, OUT_VALID} state_t;

  entry_t          mem [DEPTH];
  entry_t          out_q, new_entry;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  state_t          state, state_nxt;
  logic            strobe, in_range, pop, push, drop, oob_hit;

  // An X or Z strobe falls through the if and counts as no write.
  always_comb begin
    strobe = 1'b0;
    if (bus.draw_enable_in) strobe = 1'b1;
  end

  assign in_range = ({1'b0, bus.x_in} < 9'(SCREEN_W)) &&
                    ({1'b0, bus.y_in} < 9'(SCREEN_H));

  assign new_entry.addr   = 15'(bus.y_in) * 15'(SCREEN_W) + 15'(bus.x_in);
  assign new_entry.colour = {bus.rgb_in[23 -: CH_BITS],
                             bus.rgb_in[15 -: CH_BITS],
                             bus.rgb_in[7  -: CH_BITS]};

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      OUT_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (bus.fb_ready) begin
          if (count != '0) pop = 1'b1;
          else             state_nxt = OUT_IDLE;
        end
      end
      default: state_nxt = OUT_IDLE;
    endcase
  end

  // A full queue still takes a pixel when the head leaves on the same edge.
  assign push    = strobe && in_range && (!full || pop);
  assign drop    = strobe && in_range && full && !pop;
  assign oob_hit = strobe && !in_range;

  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OUT_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_q     <= '0;
      overflow  <= 1'b0;
      oob_count <= '0;
    end else begin
      if (oob_hit && !clear && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
      if (clear) begin
        state    <= OUT_IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        state <= state_nxt;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          out_q  <= mem[rd_ptr];
        end
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (drop) overflow <= 1'b1;
      end
    end
  end

  assign bus.fb_we     = (state == OUT_VALID);
  assign bus.fb_addr   = out_q.addr;
  assign bus.fb_colour = out_q.colour;
  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0) && (state == OUT_IDLE);
endmodule

// File: tb/tb_pixel_write_queue.sv
// Randomised and directed bench for pixel_write_queue with a queue-based
// reference model and a negedge scoreboard monitor.
module tb_pixel_write_queue;
  localparam int DEPTH   = 16;
  localparam int CH_BITS = 3;
  localparam int SW      = 160;
  localparam int SH      = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1, clear = 1'b0;
  logic       full, empty, overflow;
  logic [7:0] oob_count;

  pixel_write_queue_if #(.CH_BITS(CH_BITS)) bus ();

  pixel_write_queue #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH), .CH_BITS(CH_BITS)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus.slave),
    .full(full), .empty(empty), .overflow(overflow), .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int colour; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   m_fifo, m_oob;
  bit   m_out, m_ovf, mon_en;
  int   checks, errors, writes, last_addr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_colour(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]) >> (8 - CH_BITS);
    g = int'(rgb[15:8])  >> (8 - CH_BITS);
    b = int'(rgb[7:0])   >> (8 - CH_BITS);
    return (r << (2*CH_BITS)) | (g << CH_BITS) | b;
  endfunction

  // Reference: a FIFO of DEPTH slots feeding a single output slot.
  task automatic model_step(input bit s, input int x, input int y, input logic [23:0] rgb,
                            input bit rdy, input bit clr, input bit rst);
    bit pop;
    if (rst) begin
      m_fifo = 0; m_out = 0; m_ovf = 0; m_oob = 0; exp_q.delete();
    end else if (clr) begin
      m_fifo = 0; m_out = 0; m_ovf = 0; exp_q.delete();
    end else begin
      pop = (m_fifo > 0) && (!m_out || rdy);
      if (s) begin
        if (x >= SW || y >= SH) begin
          if (m_oob < 255) m_oob++;
        end else if (m_fifo < DEPTH || pop) begin
          m_fifo++;
          exp_q.push_back('{y * SW + x, exp_colour(rgb)});
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) begin
        m_fifo--;
        m_out = 1;
      end else if (m_out && rdy) begin
        m_out = 0;
      end
    end
  endtask

  task automatic cycle(input logic de, input int x, input int y, input logic [23:0] rgb,
                       input bit rdy, input bit clr = 0, input bit rst = 0);
    bus.draw_enable_in = de;
    bus.x_in   = 8'(x);
    bus.y_in   = 8'(y);
    bus.rgb_in = rgb;
    bus.fb_ready = rdy;
    clear = clr;
    reset = rst;
    @(posedge clk);
    model_step(de === 1'b1, x & 255, y & 255, rgb, rdy, clr, rst);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.fb_we === 1'b1 && bus.fb_ready && !clear && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("fb_addr", int'(bus.fb_addr), mon_e.addr);
          chk("fb_colour", int'(bus.fb_colour), mon_e.colour);
          writes++;
          last_addr = int'(bus.fb_addr);
        end
      end
      chk("fb_we", int'(bus.fb_we), int'(m_out));
      chk("full", int'(full), int'(m_fifo == DEPTH));
      chk("empty", int'(empty), int'(m_fifo == 0 && !m_out));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("oob_count", int'(oob_count), m_oob);
    end
  end

  initial begin
    int w0, oob0;
    logic de;
    bus.fb_ready = 1'b0;
    bus.draw_enable_in = 1'b0;
    cycle(0, 0, 0, 0, 1, 0, 1);
    mon_en = 1;
    chk("rst_fb_we", int'(bus.fb_we), 0);
    chk("rst_fb_addr", int'(bus.fb_addr), 0);
    chk("rst_fb_colour", int'(bus.fb_colour), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);

    // single write
    cycle(1, 5, 2, 24'hFF8040, 1);
    cycle(0, 0, 0, 0, 1);
    chk("t1_we", int'(bus.fb_we), 1);
    chk("t1_addr", int'(bus.fb_addr), 325);
    chk("t1_colour", int'(bus.fb_colour), 9'b111_100_010);
    cycle(0, 0, 0, 0, 1);
    chk("t1_empty", int'(empty), 1);

    // backpressure and overflow
    w0 = writes;
    for (int i = 0; i < 18; i++) cycle(1, i, 0, 24'($urandom()), 0);
    chk("t2_full", int'(full), 1);
    chk("t2_overflow", int'(overflow), 1);
    for (int i = 0; i < 22; i++) cycle(0, 0, 0, 0, 1);
    chk("t2_writes", writes - w0, 17);
    chk("t2_empty", int'(empty), 1);
    cycle(0, 0, 0, 0, 1, 1);

    // boundaries
    cycle(1, 159, 119, 24'h123456, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("t3_corner_addr", last_addr, 19199);
    w0 = writes;
    cycle(1, 160, 0, 24'hFFFFFF, 1);
    cycle(1, 0, 120, 24'hFFFFFF, 1);
    cycle(1, 255, 255, 24'hFFFFFF, 1);
    cycle(0, 0, 0, 0, 1);
    chk("t3_oob3", int'(oob_count), 3);
    chk("t3_no_write", writes - w0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 200, 7, 0, 1);
    chk("t3_oob_sat", int'(oob_count), 255);

    // full with simultaneous pop
    for (int i = 0; i < 17; i++) cycle(1, i, 3, 24'($urandom()), 0);
    chk("t4_full", int'(full), 1);
    cycle(1, 50, 50, 24'hA0B0C0, 1);
    chk("t4_overflow", int'(overflow), 0);
    chk("t4_still_full", int'(full), 1);
    for (int i = 0; i < 22; i++) cycle(0, 0, 0, 0, 1);

    // streaming
    w0 = writes;
    for (int i = 0; i < 40; i++) begin
      cycle(1, i, 1, 24'($urandom()), 1);
      if (i > 0) chk("t5_we", int'(bus.fb_we), 1);
      chk("t5_not_full", int'(full), 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    chk("t5_writes", writes - w0, 40);

    // clear mid-handshake
    for (int i = 0; i < 6; i++) cycle(1, i, 9, 24'($urandom()), 0);
    chk("t6_we_before", int'(bus.fb_we), 1);
    oob0 = int'(oob_count);
    cycle(1, 3, 3, 24'h0, 1, 1);
    chk("t6_clr_we", int'(bus.fb_we), 0);
    chk("t6_clr_empty", int'(empty), 1);
    chk("t6_clr_ovf", int'(overflow), 0);
    chk("t6_clr_oob", int'(oob_count), oob0);
    for (int i = 0; i < 6; i++) cycle(1, i, 9, 24'($urandom()), 0);
    cycle(0, 0, 0, 0, 1, 0, 1);
    chk("t6_rst_we", int'(bus.fb_we), 0);
    chk("t6_rst_addr", int'(bus.fb_addr), 0);
    chk("t6_rst_colour", int'(bus.fb_colour), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_oob", int'(oob_count), 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      de = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 99) < 2) de = 1'bx;
      cycle(de, $urandom_range(0, 170), $urandom_range(0, 125), 24'($urandom()),
            $urandom_range(0, 99) < 65, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 25; i++) cycle(0, 0, 0, 0, 1);
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Sits directly downstream of the map/tile drawers on the shared pixel bus (x, y, 24-bit RGB, draw enable) and upstream of the framebuffer write port of the VGA adapter.
- Captures every pixel strobe into a FIFO and converts (x, y) to a linear framebuffer address.
- Reduces RGB888 to adapter colour depth and drains to the framebuffer with a ready/valid handshake, so drawers never stall on adapter timing.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- SCREEN_W, 160: pixels per row; also the address multiplier.
- SCREEN_H, 120: rows.
- CH_BITS, 3: bits per colour channel on the output; fb_colour width is 3*CH_BITS.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush of FIFO and output stage; counters kept
- draw_enable_in  in  1  pixel strobe from shared bus; only 1'b1 means write
- x_in  in  8  pixel column
- y_in  in  8  pixel row
- rgb_in  in  24  R=[23:16], G=[15:8], B=[7:0]
- fb_ready  in  1  framebuffer accepts the current write this cycle
- fb_we  out  1  output valid / write strobe
- fb_addr  out  15  y*SCREEN_W + x
- fb_colour  out  3*CH_BITS  {R,G,B} truncated
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO and output stage both empty
- overflow  out  1  sticky: a valid in-range pixel was dropped because the queue was full
- oob_count  out  8  saturating count of pixels rejected for out-of-range coordinates

Behaviour:
- Reset: fb_we=0, fb_addr=0, fb_colour=0, full=0, empty=1, overflow=0, oob_count=0; FIFO pointers and count are 0. Reset overrides clear and all pushes.
- Sampling: at each edge where draw_enable_in==1, the pixel is evaluated. X/Z or 0 on draw_enable_in means no write.
- Range check: if x_in>=SCREEN_W or y_in>=SCREEN_H, the pixel is not queued and oob_count increments, saturating at 255.
- Address calculation happens at push: fb_addr = y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x for the default width. Max 19199; fits 15 bits with no wrap.
- Colour calculation happens at push: fb_colour = {R[7:8-CH_BITS], G[7:8-CH_BITS], B[7:8-CH_BITS]}, truncated with no rounding.
- Push acceptance: an in-range pixel is accepted if the FIFO is not full, OR if it is full and a pop occurs in the same cycle.
  - Otherwise it is dropped and overflow is set to 1, held until reset or clear.
- Output stage: two-state machine.
  - OUT_IDLE: fb_we=0. If the FIFO is non-empty, pop the head into the output register and go to OUT_VALID.
  - OUT_VALID: fb_we=1; fb_addr and fb_colour are held stable until an edge with fb_ready=1.
    - On that edge, if the FIFO is non-empty, pop the next entry into the output register (back-to-back, fb_we stays 1).
    - If the FIFO is empty, go to OUT_IDLE.
- Latency: a pixel pushed into an empty queue at edge N is popped to the output at edge N+1; fb_we=1 during cycle N+1..N+2. Sustained throughput is 1 pixel/clk while fb_ready=1.
- Ordering: strict FIFO. No coalescing of duplicate addresses.
- Simultaneous push+pop when empty: the pushed entry is not bypassed; it is popped no earlier than the next edge.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
  - full = (count==DEPTH).
  - empty = (count==0 && state==OUT_IDLE).
- clear: at the edge, count=0, pointers=0, state=OUT_IDLE, fb_we=0, overflow=0. A pixel strobed in the same cycle as clear is discarded. oob_count is unaffected.
- Reset or clear mid-handshake abandons the pending write; no fb_we pulse is generated for it.

Test Plan:
1. Single write: reset, then strobe x=5,y=2,rgb=24'hFF8040 with fb_ready=1 -> fb_we high one cycle later, fb_addr=325, fb_colour=9'b111_100_010; then empty=1.
2. Backpressure: hold fb_ready=0, strobe 16 pixels at (i,0), then 2 more -> full=1, overflow=1. After fb_ready=1, exactly 17 writes with addr 0..16 in order: 1 in the output register plus 16 in the FIFO, the 18th pixel dropped.
3. Boundaries: (159,119) -> addr 19199 accepted. Then (160,0), (0,120), (255,255) -> no fb_we, oob_count=3. Drive 300 OOB strobes -> oob_count=255.
4. Full with simultaneous pop: fill to full with fb_ready=0, then set fb_ready=1 and strobe in the same cycle -> pixel accepted, overflow stays 0, count remains DEPTH.
5. Streaming: continuous strobes with fb_ready=1 for 40 cycles -> fb_we high every cycle after the first, addresses in order, full never 1.
6. Flush/reset: with 5 queued and fb_we=1, pulse clear -> next cycle fb_we=0, empty=1, overflow=0, oob_count unchanged. Repeat with reset -> all outputs at reset values.
